// File: rtl/page_cmd_arbiter_pkg.sv
// Shared definitions for the page-command arbiter: source codes, FSM states and page opcodes.
package page_cmd_arbiter_pkg;

    localparam logic SRC_RD = 1'b0;
    localparam logic SRC_WR = 1'b1;

    localparam logic [15:0] PCMD_READ = 16'h3000;
    localparam logic [15:0] PCMD_CORD = 16'h3500;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCK_RD = 2'd1,
        ARB_LOCK_WR = 2'd2
    } arb_state_e;

    // Width of the watchdog idle counter; a disabled or 1-cycle watchdog still needs one bit.
    function automatic int unsigned tmo_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/page_cmd_slot.sv
// Single-entry valid/ready register; accepts a new entry whenever empty or draining this cycle.
module page_cmd_slot
    import page_cmd_arbiter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_can_take,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        o_can_take = !valid_q | i_ready;
        valid_d    = valid_q;
        data_d     = data_q;
        if (o_can_take) begin
            valid_d = i_valid;
            if (i_valid) begin
                data_d = i_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/page_cmd_arbiter.sv
// Round-robin, command-granular arbiter sharing the page-command port between RD and WR schedulers.
module page_cmd_arbiter
    import page_cmd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 48,
    parameter int unsigned ID_W    = 16,
    parameter int unsigned PARAM_W = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rd_valid,
    output logic               o_rd_ready,
    input  logic [15:0]        i_rd_cmd,
    input  logic               i_rd_last,
    input  logic [ID_W-1:0]    i_rd_id,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    input  logic [PARAM_W-1:0] i_rd_param,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [15:0]        i_wr_cmd,
    input  logic               i_wr_last,
    input  logic [ID_W-1:0]    i_wr_id,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [PARAM_W-1:0] i_wr_param,
    output logic               o_page_cmd_valid,
    input  logic               i_page_cmd_ready,
    output logic [15:0]        o_page_cmd,
    output logic               o_page_cmd_last,
    output logic [ID_W-1:0]    o_page_cmd_id,
    output logic [ADDR_W-1:0]  o_page_addr,
    output logic [PARAM_W-1:0] o_page_cmd_param,
    output logic               o_page_src,
    output logic [CNT_W-1:0]   o_rd_beats,
    output logic [CNT_W-1:0]   o_wr_beats,
    output logic               o_lock_err
);

    localparam int unsigned PAY_W = 16 + 1 + ID_W + ADDR_W + PARAM_W + 1;
    localparam int unsigned TMO_W = tmo_width(TMO_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

    arb_state_e       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic             lock_err_q, lock_err_d;
    logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] rd_beats_q, rd_beats_d;
    logic [CNT_W-1:0] wr_beats_q, wr_beats_d;

    logic             can_take;
    logic             rd_pick, wr_pick;
    logic             rd_acc, wr_acc, acc, acc_last;
    logic             own_valid, wd_tick, wd_expire;
    logic [PAY_W-1:0] pay_in, pay_out;

    // Grants go only to a valid source in IDLE; readys are held low while reset is asserted.
    always_comb begin
        rd_pick    = i_rd_valid & (!i_wr_valid | (last_owner_q == SRC_WR));
        wr_pick    = i_wr_valid & !rd_pick;
        o_rd_ready = !rst & can_take &
                     ((state_q == ARB_LOCK_RD) | ((state_q == ARB_IDLE) & rd_pick));
        o_wr_ready = !rst & can_take &
                     ((state_q == ARB_LOCK_WR) | ((state_q == ARB_IDLE) & wr_pick));
        rd_acc     = o_rd_ready & i_rd_valid;
        wr_acc     = o_wr_ready & i_wr_valid;
        acc        = rd_acc | wr_acc;
        acc_last   = wr_acc ? i_wr_last : i_rd_last;
        pay_in     = wr_acc ? {i_wr_cmd, i_wr_last, i_wr_id, i_wr_addr, i_wr_param, SRC_WR}
                            : {i_rd_cmd, i_rd_last, i_rd_id, i_rd_addr, i_rd_param, SRC_RD};
    end

    // An accepted beat always takes precedence over a watchdog expiry in the same cycle.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        lock_err_d   = lock_err_q;
        idle_cnt_d   = idle_cnt_q;
        rd_beats_d   = rd_beats_q + CNT_W'(rd_acc);
        wr_beats_d   = wr_beats_q + CNT_W'(wr_acc);
        own_valid    = (state_q == ARB_LOCK_RD) ? i_rd_valid : i_wr_valid;
        wd_tick      = (TMO_CYC != 0) && (state_q != ARB_IDLE) && !own_valid && can_take;
        wd_expire    = wd_tick && (idle_cnt_q == TMO_LAST);

        if (acc) begin
            idle_cnt_d = '0;
            if (acc_last) begin
                state_d      = ARB_IDLE;
                last_owner_d = wr_acc;
            end else begin
                state_d = wr_acc ? ARB_LOCK_WR : ARB_LOCK_RD;
            end
        end else if (wd_expire) begin
            state_d      = ARB_IDLE;
            lock_err_d   = 1'b1;
            last_owner_d = (state_q == ARB_LOCK_WR) ? SRC_WR : SRC_RD;
            idle_cnt_d   = '0;
        end else if (wd_tick) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= SRC_WR;
            lock_err_q   <= 1'b0;
            idle_cnt_q   <= '0;
            rd_beats_q   <= '0;
            wr_beats_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            lock_err_q   <= lock_err_d;
            idle_cnt_q   <= idle_cnt_d;
            rd_beats_q   <= rd_beats_d;
            wr_beats_q   <= wr_beats_d;
        end
    end

    page_cmd_slot #(
        .W(PAY_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (acc),
        .o_can_take(can_take),
        .i_data    (pay_in),
        .o_valid   (o_page_cmd_valid),
        .i_ready   (i_page_cmd_ready),
        .o_data    (pay_out)
    );

    assign {o_page_cmd, o_page_cmd_last, o_page_cmd_id, o_page_addr,
            o_page_cmd_param, o_page_src} = pay_out;

    assign o_rd_beats = rd_beats_q;
    assign o_wr_beats = wr_beats_q;
    assign o_lock_err = lock_err_q;

endmodule

// File: tb/tb_page_cmd_arbiter.sv
// Directed bench for page_cmd_arbiter: arbitration order, command locking, stall, watchdog and reset.
module tb_page_cmd_arbiter;
    import page_cmd_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_valid = 1'b0, rd_last = 1'b0;
    logic [15:0] rd_cmd = '0;
    logic [15:0] rd_id = '0;
    logic [47:0] rd_addr = '0;
    logic [31:0] rd_param = '0;
    logic        wr_valid = 1'b0, wr_last = 1'b0;
    logic [15:0] wr_cmd = '0;
    logic [15:0] wr_id = '0;
    logic [47:0] wr_addr = '0;
    logic [31:0] wr_param = '0;
    logic        pc_ready = 1'b0;

    logic        rd_ready, wr_ready, pc_valid, pc_last, pc_src, lock_err;
    logic [15:0] pc_cmd, pc_id, rd_beats, wr_beats;
    logic [47:0] pc_addr;
    logic [31:0] pc_param;

    int checks = 0;
    int failures = 0;

    page_cmd_arbiter #(
        .ADDR_W (48),
        .ID_W   (16),
        .PARAM_W(32),
        .CNT_W  (16),
        .TMO_CYC(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rd_valid      (rd_valid),
        .o_rd_ready      (rd_ready),
        .i_rd_cmd        (rd_cmd),
        .i_rd_last       (rd_last),
        .i_rd_id         (rd_id),
        .i_rd_addr       (rd_addr),
        .i_rd_param      (rd_param),
        .i_wr_valid      (wr_valid),
        .o_wr_ready      (wr_ready),
        .i_wr_cmd        (wr_cmd),
        .i_wr_last       (wr_last),
        .i_wr_id         (wr_id),
        .i_wr_addr       (wr_addr),
        .i_wr_param      (wr_param),
        .o_page_cmd_valid(pc_valid),
        .i_page_cmd_ready(pc_ready),
        .o_page_cmd      (pc_cmd),
        .o_page_cmd_last (pc_last),
        .o_page_cmd_id   (pc_id),
        .o_page_addr     (pc_addr),
        .o_page_cmd_param(pc_param),
        .o_page_src      (pc_src),
        .o_rd_beats      (rd_beats),
        .o_wr_beats      (wr_beats),
        .o_lock_err      (lock_err)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [163:0] all_out;
        @(negedge clk);
        all_out = {rd_ready, wr_ready, pc_valid, pc_cmd, pc_last, pc_id, pc_addr, pc_param,
                   pc_src, rd_beats, wr_beats, lock_err};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", all_out);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_rd_single();
        pc_ready = 1'b1;
        rd_valid = 1'b1; rd_cmd = PCMD_READ; rd_last = 1'b1; rd_id = 16'd5;
        rd_addr = 48'h1234_5678_9abc; rd_param = 32'hdead_beef;
        @(negedge clk);
        checks++;
        if ({rd_ready, wr_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready got=%b exp=10", {rd_ready, wr_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pc_valid, pc_src, pc_id, pc_cmd, pc_last} !== {1'b1, 1'b0, 16'd5, 16'h3000, 1'b1}) begin
            failures++;
            $display("FAIL single_slot got=%0h exp=%0h", {pc_valid, pc_src, pc_id, pc_cmd, pc_last},
                     {1'b1, 1'b0, 16'd5, 16'h3000, 1'b1});
        end
        checks++;
        if ({pc_addr, pc_param} !== {48'h1234_5678_9abc, 32'hdead_beef}) begin
            failures++;
            $display("FAIL single_payload got=%0h exp=%0h", {pc_addr, pc_param},
                     {48'h1234_5678_9abc, 32'hdead_beef});
        end
        checks++;
        if ({rd_beats, wr_beats} !== {16'd1, 16'd0}) begin
            failures++;
            $display("FAIL single_beats got=%0h exp=%0h", {rd_beats, wr_beats}, {16'd1, 16'd0});
        end
        rd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%b exp=0", pc_valid);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_src;
        logic [15:0] exp_id;
        apply_reset();
        pc_ready = 1'b1;
        rd_valid = 1'b1; rd_last = 1'b1; rd_id = 16'h11; rd_cmd = PCMD_CORD;
        wr_valid = 1'b1; wr_last = 1'b1; wr_id = 16'h21; wr_cmd = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            exp_src = i[0];
            exp_id  = exp_src ? wr_id : rd_id;
            @(negedge clk);
            checks++;
            if ({rd_ready, wr_ready} !== {!exp_src, exp_src}) begin
                failures++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", i, {rd_ready, wr_ready}, {!exp_src, exp_src});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({pc_valid, pc_src, pc_id} !== {1'b1, exp_src, exp_id}) begin
                failures++;
                $display("FAIL rr_slot[%0d] got=%0h exp=%0h", i, {pc_valid, pc_src, pc_id},
                         {1'b1, exp_src, exp_id});
            end
            if (!exp_src) begin
                rd_id = rd_id + 16'd1;
                if (i >= 2) rd_valid = 1'b0;
            end else begin
                wr_id = wr_id + 16'd1;
                if (i >= 2) wr_valid = 1'b0;
            end
        end
        checks++;
        if ({rd_beats, wr_beats} !== {16'd2, 16'd2}) begin
            failures++;
            $display("FAIL rr_beats got=%0h exp=%0h", {rd_beats, wr_beats}, {16'd2, 16'd2});
        end
    endtask

    task automatic test_lock();
        rd_valid = 1'b1; rd_last = 1'b0; rd_id = 16'h30;
        wr_valid = 1'b1; wr_last = 1'b1; wr_id = 16'h3a;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({rd_ready, wr_ready} !== 2'b10) begin
                failures++;
                $display("FAIL lock_ready[%0d] got=%b exp=10", k, {rd_ready, wr_ready});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({pc_src, pc_id, pc_last} !== {1'b0, 16'h30 + 16'(k), k == 2}) begin
                failures++;
                $display("FAIL lock_slot[%0d] got=%0h exp=%0h", k, {pc_src, pc_id, pc_last},
                         {1'b0, 16'h30 + 16'(k), k == 2});
            end
            rd_id   = rd_id + 16'd1;
            rd_last = (k == 1);
            if (k == 2) rd_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({rd_ready, wr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL lock_wr_grant got=%b exp=01", {rd_ready, wr_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pc_src, pc_id} !== {1'b1, 16'h3a}) begin
            failures++;
            $display("FAIL lock_wr_slot got=%0h exp=%0h", {pc_src, pc_id}, {1'b1, 16'h3a});
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_stall();
        rd_valid = 1'b1; rd_last = 1'b1; rd_id = 16'h40;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_first_ready got=%b exp=1", rd_ready);
        end
        @(posedge clk);
        #1;
        pc_ready = 1'b0;
        rd_id = 16'h41;
        wr_valid = 1'b1; wr_last = 1'b1; wr_id = 16'h50;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({pc_valid, pc_id, rd_ready, wr_ready} !== {1'b1, 16'h40, 2'b00}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%0h exp=%0h", c, {pc_valid, pc_id, rd_ready, wr_ready},
                         {1'b1, 16'h40, 2'b00});
            end
        end
        @(posedge clk);
        #1 pc_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_valid, pc_id, rd_ready, wr_ready} !== {1'b1, 16'h40, 2'b01}) begin
            failures++;
            $display("FAIL stall_release got=%0h exp=%0h", {pc_valid, pc_id, rd_ready, wr_ready},
                     {1'b1, 16'h40, 2'b01});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pc_valid, pc_src, pc_id} !== {1'b1, 1'b1, 16'h50}) begin
            failures++;
            $display("FAIL stall_refill got=%0h exp=%0h", {pc_valid, pc_src, pc_id}, {1'b1, 1'b1, 16'h50});
        end
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({pc_valid, pc_src, pc_id} !== {1'b1, 1'b0, 16'h41}) begin
            failures++;
            $display("FAIL stall_next got=%0h exp=%0h", {pc_valid, pc_src, pc_id}, {1'b1, 1'b0, 16'h41});
        end
        rd_valid = 1'b0;
    endtask

    task automatic test_watchdog();
        rd_valid = 1'b1; rd_last = 1'b0; rd_id = 16'h60;
        @(negedge clk);
        checks++;
        if ({rd_ready, wr_ready} !== 2'b10) begin
            failures++;
            $display("FAIL wd_start_ready got=%b exp=10", {rd_ready, wr_ready});
        end
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        wr_valid = 1'b1; wr_last = 1'b1; wr_id = 16'h70;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({lock_err, wr_ready} !== {j == 8, j == 8}) begin
                failures++;
                $display("FAIL wd_cycle[%0d] got=%b exp=%b", j, {lock_err, wr_ready}, {j == 8, j == 8});
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pc_valid, pc_src, pc_id, lock_err} !== {1'b1, 1'b1, 16'h70, 1'b1}) begin
            failures++;
            $display("FAIL wd_wr_slot got=%0h exp=%0h", {pc_valid, pc_src, pc_id, lock_err},
                     {1'b1, 1'b1, 16'h70, 1'b1});
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_lock();
        logic [163:0] all_out;
        wr_valid = 1'b1; wr_last = 1'b0; wr_id = 16'h80;
        @(negedge clk);
        checks++;
        if ({rd_ready, wr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rml_wr_ready got=%b exp=01", {rd_ready, wr_ready});
        end
        @(posedge clk);
        #1;
        pc_ready = 1'b0;
        wr_id = 16'h81;
        rd_valid = 1'b1; rd_last = 1'b1; rd_id = 16'h90;
        checks++;
        if ({pc_valid, pc_src, pc_id, rd_beats, wr_beats} !== {1'b1, 1'b1, 16'h80, 16'd8, 16'd6}) begin
            failures++;
            $display("FAIL rml_before got=%0h exp=%0h", {pc_valid, pc_src, pc_id, rd_beats, wr_beats},
                     {1'b1, 1'b1, 16'h80, 16'd8, 16'd6});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        all_out = {rd_ready, wr_ready, pc_valid, pc_cmd, pc_last, pc_id, pc_addr, pc_param,
                   pc_src, rd_beats, wr_beats, lock_err};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL rml_outputs got=%0h exp=0", all_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_last = 1'b1;
        pc_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_ready, wr_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rml_tie got=%b exp=10", {rd_ready, wr_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pc_valid, pc_src, pc_id} !== {1'b1, 1'b0, 16'h90}) begin
            failures++;
            $display("FAIL rml_slot got=%0h exp=%0h", {pc_valid, pc_src, pc_id}, {1'b1, 1'b0, 16'h90});
        end
        rd_valid = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rd_single();
        test_round_robin();
        test_lock();
        test_stall();
        test_watchdog();
        test_reset_mid_lock();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
